// File: rtl/popcount_seq_ctrl_if.sv
// Handshake bundle for the popcount sequencer: vector in, count out, plus busy status.
interface popcount_seq_ctrl_if #(
    parameter int VEC_WIDTH = 256,
    parameter int CNT_WIDTH = $clog2(VEC_WIDTH + 1)
);
    logic                 in_valid;
    logic                 in_ready;
    logic [VEC_WIDTH-1:0] din;
    logic                 out_valid;
    logic                 out_ready;
    logic [CNT_WIDTH-1:0] count;
    logic                 busy;

    // Producer/consumer side (feature buffer and threshold stage)
    modport master (
        output in_valid,
        output din,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  count,
        input  busy
    );

    // Sequencer side
    modport slave (
        input  in_valid,
        input  din,
        input  out_ready,
        output in_ready,
        output out_valid,
        output count,
        output busy
    );
endinterface

// File: rtl/popcount_seq_ctrl.sv
// Multi-cycle popcount sequencer: walks a captured vector through LANES six-input
// popcount LUTs, one SLICE per beat, and accumulates the lane sums into a total.

// Six-input popcount primitive; one per lane, maps onto a single LUT6 per output bit.
module LUT6_Popcount #(
    parameter int DIN_WIDTH  = 6,
    parameter int DOUT_WIDTH = 3
) (
    input  logic [DIN_WIDTH-1:0]  din,
    output logic [DOUT_WIDTH-1:0] dout
);
    logic [DOUT_WIDTH-1:0] dout_s;

    // Count the set bits of the six-bit input
    always_comb begin
        dout_s = {DOUT_WIDTH{1'b0}};
        for (int i = 0; i < DIN_WIDTH; i++) begin
            dout_s = dout_s + DOUT_WIDTH'(din[i]);
        end
    end

    assign dout = dout_s;
endmodule

module popcount_seq_ctrl #(
    parameter int VEC_WIDTH = 256,
    parameter int LANES     = 8,
    parameter int CNT_WIDTH = $clog2(VEC_WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    popcount_seq_ctrl_if.slave bus
);
    localparam int SLICE    = 6 * LANES;
    localparam int NBEATS   = (VEC_WIDTH + SLICE - 1) / SLICE;
    localparam int BEAT_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int SHADOW_W = NBEATS * SLICE;
    localparam int TREE_W   = $clog2(SLICE + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_r;
    state_t                state_nx_s;
    logic                  accept_s;
    logic                  out_hs_s;
    logic                  last_beat_s;

    logic [SHADOW_W-1:0]   shadow_r;
    logic [BEAT_W-1:0]     beat_r;
    logic [CNT_WIDTH-1:0]  acc_r;

    logic [SLICE-1:0]      slice_s;
    logic [2:0]            lane_cnt_s [LANES];
    logic [TREE_W-1:0]     tree_sum_s;

    logic                  in_ready_r;
    logic                  out_valid_r;
    logic [CNT_WIDTH-1:0]  count_r;
    logic                  busy_r;

    // The shadow register shifts down one slice per beat, so the active slice is always the bottom one.
    assign slice_s     = shadow_r[SLICE-1:0];
    assign last_beat_s = (beat_r == BEAT_W'(NBEATS - 1));

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        LUT6_Popcount #(
            .DIN_WIDTH  (6),
            .DOUT_WIDTH (3)
        ) u_lut (
            .din  (slice_s[g*6 +: 6]),
            .dout (lane_cnt_s[g])
        );
    end

    // Sum the lane counts for the current slice
    always_comb begin
        tree_sum_s = {TREE_W{1'b0}};
        for (int l = 0; l < LANES; l++) begin
            tree_sum_s = tree_sum_s + TREE_W'(lane_cnt_s[l]);
        end
    end

    // Next-state and handshake decode
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        out_hs_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    accept_s   = 1'b1;
                    state_nx_s = S_RUN;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (last_beat_s) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_RUN;
                end
            end
            S_DONE: begin
                if (out_valid_r && bus.out_ready) begin
                    out_hs_s   = 1'b1;
                    state_nx_s = S_IDLE;
                end else begin
                    state_nx_s = S_DONE;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Capture, per-beat accumulation and beat counting
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r <= {SHADOW_W{1'b0}};
            beat_r   <= {BEAT_W{1'b0}};
            acc_r    <= {CNT_WIDTH{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        // Zero-extension pads the tail slice, so bits beyond VEC_WIDTH count as 0
                        shadow_r <= SHADOW_W'(bus.din);
                        beat_r   <= {BEAT_W{1'b0}};
                        acc_r    <= {CNT_WIDTH{1'b0}};
                    end else begin
                        shadow_r <= shadow_r;
                        beat_r   <= beat_r;
                        acc_r    <= acc_r;
                    end
                end
                S_RUN: begin
                    // Total never exceeds VEC_WIDTH, so the narrowing cast cannot drop set bits
                    acc_r    <= acc_r + CNT_WIDTH'(tree_sum_s);
                    shadow_r <= shadow_r >> SLICE;
                    if (last_beat_s) begin
                        beat_r <= beat_r;
                    end else begin
                        beat_r <= beat_r + BEAT_W'(1);
                    end
                end
                default: begin
                    shadow_r <= shadow_r;
                    beat_r   <= beat_r;
                    acc_r    <= acc_r;
                end
            endcase
        end
    end

    // Registered status/output stage; count is forced to 0 whenever it is not valid
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            count_r     <= {CNT_WIDTH{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            in_ready_r <= (state_nx_s == S_IDLE);
            busy_r     <= (state_nx_s != S_IDLE);
            if ((state_r == S_DONE) && !out_hs_s) begin
                out_valid_r <= 1'b1;
                count_r     <= acc_r;
            end else begin
                out_valid_r <= 1'b0;
                count_r     <= {CNT_WIDTH{1'b0}};
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.count     = count_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_popcount_seq_ctrl.sv
// Self-checking bench: default-size DUT for directed cases, 50-bit/2-lane DUT for random traffic,
// both watched every cycle by a transaction-level popcount model.
module tb_popcount_seq_ctrl;
    logic clk;
    logic rst0;
    logic rst1;

    popcount_seq_ctrl_if #(.VEC_WIDTH(256)) if0 ();
    popcount_seq_ctrl_if #(.VEC_WIDTH(50))  if1 ();

    popcount_seq_ctrl #(.VEC_WIDTH(256), .LANES(8)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (if0.slave)
    );

    popcount_seq_ctrl #(.VEC_WIDTH(50), .LANES(2)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ceil(256/48)=6 and ceil(50/12)=5, worked out by hand
    int nbeats [2] = '{6, 5};

    int n_chk  = 0;
    int n_fail = 0;
    int nacc [2] = '{0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // A vector is outstanding from its accepting edge until its output handshake.
    // in_ready/busy follow "nothing outstanding", out_valid rises NBEATS+1 edges after
    // acceptance, and count must equal the popcount of the accepted vector.
    int  mq [2][$];
    int  acc_edge [2];
    bit  p_rst [2];
    bit  p_acc [2];
    bit  p_hs  [2];
    bit  armed [2];
    int  p_pc  [2];
    int  cyc = 0;

    always @(negedge clk) begin
        logic iv [2];
        logic ordy [2];
        logic ir [2];
        logic ov [2];
        logic bz [2];
        logic rs [2];
        int   cnt [2];
        int   pc [2];
        bit   exp_ov;
        cyc++;
        iv[0] = if0.in_valid;  iv[1] = if1.in_valid;
        ordy[0] = if0.out_ready; ordy[1] = if1.out_ready;
        ir[0] = if0.in_ready;  ir[1] = if1.in_ready;
        ov[0] = if0.out_valid; ov[1] = if1.out_valid;
        bz[0] = if0.busy;      bz[1] = if1.busy;
        rs[0] = rst0;          rs[1] = rst1;
        cnt[0] = int'(if0.count); cnt[1] = int'(if1.count);
        pc[0] = $countones(if0.din); pc[1] = $countones(if1.din);
        for (int d = 0; d < 2; d++) begin
            exp_ov = 1'b0;
            if (p_rst[d]) begin
                mq[d].delete();
                armed[d] = 1'b1;
            end else begin
                if (p_hs[d] && mq[d].size() > 0) void'(mq[d].pop_front());
                if (p_acc[d]) begin
                    mq[d].push_back(p_pc[d]);
                    acc_edge[d] = cyc;
                    nacc[d]++;
                end
            end
            if (armed[d]) begin
                exp_ov = (mq[d].size() > 0) && ((cyc - acc_edge[d]) >= nbeats[d] + 1);
                chk($sformatf("d%0d_in_ready", d), 32'(ir[d]), 32'(mq[d].size() == 0));
                chk($sformatf("d%0d_busy", d), 32'(bz[d]), 32'(mq[d].size() != 0));
                chk($sformatf("d%0d_out_valid", d), 32'(ov[d]), 32'(exp_ov));
                chk($sformatf("d%0d_count", d), cnt[d], exp_ov ? mq[d][0] : 0);
            end
            p_rst[d] = rs[d];
            p_acc[d] = armed[d] && !rs[d] && iv[d] && (mq[d].size() == 0);
            p_hs[d]  = armed[d] && !rs[d] && exp_ov && ordy[d];
            p_pc[d]  = pc[d];
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send0(input logic [255:0] v);
        int n;
        n = 0;
        while (if0.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send0_wait_ready", 32'(n < 100), 32'd1);
        if0.in_valid = 1'b1;
        if0.din      = v;
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        if0.din      = {8{$urandom()}};
    endtask

    task automatic run0(input string name, input logic [255:0] v, input int exp_cnt);
        int k;
        if0.out_ready = 1'b1;
        send0(v);
        k = 0;
        while (if0.out_valid !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk({name, "_latency"}, k, 32'd7);
        chk({name, "_count"}, 32'(if0.count), exp_cnt);
        @(posedge clk); #1;
        chk({name, "_ready_after_hs"}, 32'(if0.in_ready), 32'd1);
        chk({name, "_valid_after_hs"}, 32'(if0.out_valid), 32'd0);
    endtask

    initial begin
        logic [255:0] ones;
        logic [255:0] v;
        logic [63:0]  r;
        int k;
        int guard;

        ones = '1;
        rst0 = 1'b1; rst1 = 1'b1;
        if0.in_valid = 1'b0; if0.din = '0; if0.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.din = '0; if1.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0;

        // Reset state
        chk("reset_in_ready", 32'(if0.in_ready), 32'd1);
        chk("reset_out_valid", 32'(if0.out_valid), 32'd0);
        chk("reset_busy", 32'(if0.busy), 32'd0);
        chk("reset_count", 32'(if0.count), 32'd0);
        chk("reset_in_ready_d1", 32'(if1.in_ready), 32'd1);
        @(posedge clk); #1;

        // 1..3: fixed patterns with hand-computed totals
        run0("t1_zero", 256'd0, 0);
        run0("t2_ones", ones, 256);
        v = {64{4'h5}};
        run0("t2_alt", v, 128);
        v = 256'd1 << 255;
        run0("t3_msb", v, 1);
        run0("t3_lsb", 256'd1, 1);

        // A few random vectors on the wide instance
        for (int i = 0; i < 10; i++) begin
            v = {8{$urandom()}};
            run0("rand0", v, $countones(v));
        end

        // 4: output stall with a competing in_valid
        if0.out_ready = 1'b0;
        send0(256'hF0);
        k = 0;
        while (if0.out_valid !== 1'b1 && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        chk("t4_latency", k, 32'd7);
        if0.in_valid = 1'b1;
        if0.din      = ones;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("t4_hold_valid", 32'(if0.out_valid), 32'd1);
            chk("t4_hold_count", 32'(if0.count), 32'd4);
            chk("t4_hold_not_ready", 32'(if0.in_ready), 32'd0);
        end
        if0.in_valid  = 1'b0;
        if0.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_released_valid", 32'(if0.out_valid), 32'd0);
        chk("t4_released_ready", 32'(if0.in_ready), 32'd1);
        @(posedge clk); #1;
        chk("t4_no_second_hs", 32'(if0.out_valid), 32'd0);
        chk("t4_idle_busy", 32'(if0.busy), 32'd0);

        // 5: reset while the third slice has been consumed (beat 3 active)
        if0.out_ready = 1'b1;
        send0(ones);
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        chk("t5_in_ready", 32'(if0.in_ready), 32'd1);
        chk("t5_out_valid", 32'(if0.out_valid), 32'd0);
        chk("t5_busy", 32'(if0.busy), 32'd0);
        k = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (if0.out_valid === 1'b1) k++;
        end
        chk("t5_no_output", k, 32'd0);
        run0("t5_fresh", ones, 256);

        // 6: narrow instance, random traffic with random gaps and back-pressure
        guard = 0;
        while (nacc[1] < 500 && guard < 20000) begin
            r = {$urandom(), $urandom()};
            case ($urandom_range(0, 7))
                0:       if1.din = '0;
                1:       if1.din = '1;
                default: if1.din = r[49:0];
            endcase
            if1.in_valid  = ($urandom_range(0, 3) != 0);
            if1.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            guard++;
        end
        chk("t6_vectors_done", 32'(nacc[1] >= 500), 32'd1);
        if1.in_valid  = 1'b0;
        if1.out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("t6_drained", 32'(if1.busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nacc[0] + nacc[1], n_fail);
        $finish;
    end
endmodule
